// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART transmitter types and line constants
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam logic PAR_EVEN   = 1'b0;
  localparam logic PAR_ODD    = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// rtl/uart_tx_parity_calc.sv - combinational parity bit over the latched frame data
module uart_tx_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  par_typ_i,
  output logic                  parity_o
);

  assign parity_o = (par_typ_i == PAR_ODD) ? ~^data_i : ^data_i;

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART serial transmitter (start, LSB-first data, optional parity, stop)
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            prescale,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  uart_state_e           state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [5:0]            presc_q;
  logic [5:0]            cnt_q;
  logic [BIT_W-1:0]      bit_q;
  logic                  tx_q;
  logic                  busy_q;
  logic                  par_en_q;
  logic                  parity_bit;
  logic                  bit_end;

`ifdef UART_TX_PARITY_EN
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_typ_q;

  uart_tx_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data_i    (data_q),
    .par_typ_i (par_typ_q),
    .parity_o  (parity_bit)
  );
`else
  logic unused_par_inputs;
  assign unused_par_inputs = PAR_EN ^ PAR_TYP;
  assign parity_bit        = 1'b0;
`endif

  // presc_q is clamped to >=1 at accept, so the last cycle of a bit is presc_q-1
  assign bit_end = (cnt_q == presc_q - 6'd1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      presc_q   <= 6'd0;
      cnt_q     <= 6'd0;
      bit_q     <= '0;
      tx_q      <= IDLE_LEVEL;
      busy_q    <= 1'b0;
      par_en_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      data_q    <= '0;
      par_typ_q <= PAR_EVEN;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (Data_Valid) begin
            state_q  <= START;
            shift_q  <= P_DATA;
            presc_q  <= (prescale == 6'd0) ? 6'd1 : prescale;
            cnt_q    <= 6'd0;
            bit_q    <= '0;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= PAR_EN;
            data_q    <= P_DATA;
            par_typ_q <= PAR_TYP;
`else
            par_en_q <= 1'b0;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            state_q <= DATA;
            cnt_q   <= 6'd0;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q <= 6'd0;
            if (bit_q == LAST_BIT) begin
              if (par_en_q) begin
                state_q <= PARITY;
                tx_q    <= parity_bit;
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_q   <= bit_q + 1'b1;
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        PARITY: begin
          if (bit_end) begin
            state_q <= STOP;
            cnt_q   <= 6'd0;
            tx_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            tx_q    <= IDLE_LEVEL;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= IDLE_LEVEL;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx (parity cases need UART_TX_PARITY_EN)
module tb_uart_tx;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] prescale;
  logic       TX_OUT;
  logic       busy;

  int checks = 0;
  int errors = 0;

  uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .prescale   (prescale),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Request at the current negedge; returns at the negedge after the accept edge
  // with inputs scrambled so any unlatched use of them shows up on the line.
  task automatic req(input logic [7:0] d, input logic [5:0] p, input logic pe, input logic pt);
    P_DATA     = d;
    prescale   = p;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    P_DATA     = ~d;
    prescale   = p + 6'd3;
    PAR_EN     = ~pe;
    PAR_TYP    = ~pt;
  endtask

  // pat[i] is the i-th serial bit on the line; pulse_at injects a mid-frame request.
  task automatic expect_frame(input string name, input logic [10:0] pat, input int nbits,
                              input int p, input int pulse_at);
    int pp;
    int idx;
    pp  = (p == 0) ? 1 : p;
    idx = 0;
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < pp; c++) begin
        chk($sformatf("%s tx bit%0d cyc%0d", name, i, c), TX_OUT, pat[i]);
        chk($sformatf("%s busy bit%0d cyc%0d", name, i, c), busy, 1'b1);
        Data_Valid = (idx == pulse_at);
        if (idx == pulse_at) P_DATA = 8'h00;
        idx++;
        @(negedge CLK);
      end
    end
    Data_Valid = 1'b0;
    chk({name, " busy after stop"}, busy, 1'b0);
    chk({name, " tx idle after stop"}, TX_OUT, 1'b1);
  endtask

  initial begin
    RST        = 1'b1;
    P_DATA     = 8'h00;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    prescale   = 6'd8;
    repeat (2) @(negedge CLK);
    chk("reset tx", TX_OUT, 1'b1);
    chk("reset busy", busy, 1'b0);
    RST = 1'b0;
    @(negedge CLK);
    chk("post-reset tx", TX_OUT, 1'b1);
    chk("post-reset busy", busy, 1'b0);

    // 0xA5 no parity, 8 cycles per bit: 0,1,0,1,0,0,1,0,1,1
    req(8'hA5, 6'd8, 1'b0, 1'b0);
    expect_frame("a5_nopar", 11'b0_1101001010, 10, 8, -1);

`ifdef UART_TX_PARITY_EN
    // 0xA5 even parity: parity 0 then stop, 88 busy cycles
    req(8'hA5, 6'd8, 1'b1, 1'b0);
    expect_frame("a5_even", 11'b10101001010, 11, 8, -1);
    // 0x2B odd parity: data 1,1,0,1,0,1,0,0 parity 1
    req(8'h2B, 6'd3, 1'b1, 1'b1);
    expect_frame("2b_odd", 11'b11001010110, 11, 3, -1);
`else
    // parity request ignored in this build: plain 10-bit frame
    req(8'h2B, 6'd3, 1'b1, 1'b1);
    expect_frame("2b_parity_ignored", 11'b0_1001010110, 10, 3, -1);
`endif

    // back-to-back 0x3C then 0xC3 with a mid-frame request pulse ignored
    req(8'h3C, 6'd4, 1'b0, 1'b0);
    expect_frame("3c_b2b", 11'b0_1001111000, 10, 4, 13);
    req(8'hC3, 6'd4, 1'b0, 1'b0);
    expect_frame("c3_b2b", 11'b0_1110000110, 10, 4, -1);

    // reset during data bit 3 of 0x52 (bit3 = 0)
    req(8'h52, 6'd4, 1'b0, 1'b0);
    repeat (17) @(negedge CLK);
    chk("pre-abort tx bit3", TX_OUT, 1'b0);
    chk("pre-abort busy", busy, 1'b1);
    #1 RST = 1'b1;
    #1;
    chk("abort tx", TX_OUT, 1'b1);
    chk("abort busy", busy, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk($sformatf("no resume tx cyc%0d", i), TX_OUT, 1'b1);
      chk($sformatf("no resume busy cyc%0d", i), busy, 1'b0);
    end
    req(8'h3C, 6'd2, 1'b0, 1'b0);
    expect_frame("3c_after_reset", 11'b0_1001111000, 10, 2, -1);

    // prescale 0 acts as 1: 10-cycle frame for 0xFF
    req(8'hFF, 6'd0, 1'b0, 1'b0);
    expect_frame("ff_presc0", 11'b0_1111111110, 10, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
